// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// cpu_mem_pkg : shared types/defaults for the unified-memory port arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA_WAIT = 2'd1,
      INST_WAIT = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : serialises IF fetches and MEM loads/stores onto one port
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   input  logic              d_read_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_done_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   arb_state_t        state, state_nxt;
   logic              d_served, if_served, drop;
   logic              d_served_nxt, if_served_nxt, drop_nxt;
   logic              req_nxt, we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [DATA_W-1:0] d_rdata_q, if_rdata_q, d_rdata_nxt, if_rdata_nxt;
   logic              d_act, f_act, advance;

   assign d_act     = (d_read_i | d_write_i) & ~d_served;
   assign f_act     = if_req_i & ~if_served;
   assign d_done_o  = (state == DATA_WAIT) & mem_ack_i;
   assign if_done_o = (state == INST_WAIT) & mem_ack_i & ~drop & ~flush_i;
   assign stall_o   = (d_act & ~d_done_o) | (f_act & ~if_done_o & ~flush_i);
   assign advance   = ~stall_o & ~hold_i;

   // Stores never touch the load-data register; ack cycle passes data through.
   assign d_rdata_nxt  = (d_done_o & ~mem_we_o) ? mem_rdata_i : d_rdata_q;
   assign if_rdata_nxt = if_done_o ? mem_rdata_i : if_rdata_q;
   assign d_rdata_o    = d_rdata_nxt;
   assign if_rdata_o   = if_rdata_nxt;

   always_comb begin
      state_nxt = state;
      req_nxt   = mem_req_o;
      we_nxt    = mem_we_o;
      addr_nxt  = mem_addr_o;
      wdata_nxt = mem_wdata_o;
      unique case (state)
         IDLE: begin
            if (d_act) begin
               state_nxt = DATA_WAIT;
               req_nxt   = 1'b1;
               we_nxt    = d_write_i;
               addr_nxt  = d_addr_i;
               wdata_nxt = d_wdata_i;
            end else if (f_act) begin
               state_nxt = INST_WAIT;
               req_nxt   = 1'b1;
               we_nxt    = 1'b0;
               addr_nxt  = if_addr_i;
            end
         end
         DATA_WAIT: begin
            if (mem_ack_i) begin
               if (f_act) begin
                  state_nxt = INST_WAIT;
                  we_nxt    = 1'b0;
                  addr_nxt  = if_addr_i;
               end else begin
                  state_nxt = IDLE;
                  req_nxt   = 1'b0;
                  we_nxt    = 1'b0;
               end
            end
         end
         INST_WAIT: begin
            if (mem_ack_i) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            we_nxt    = 1'b0;
         end
      endcase
   end

   always_comb begin
      d_served_nxt  = advance ? 1'b0 : (d_served | d_done_o);
      if_served_nxt = (advance | flush_i) ? 1'b0 : (if_served | if_done_o);
      drop_nxt      = drop;
      // A flushed fetch still has to drain; remember to discard its ack.
      if (state == INST_WAIT) begin
         if (mem_ack_i)    drop_nxt = 1'b0;
         else if (flush_i) drop_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         d_served    <= 1'b0;
         if_served   <= 1'b0;
         drop        <= 1'b0;
         d_rdata_q   <= '0;
         if_rdata_q  <= '0;
      end else begin
         state       <= state_nxt;
         mem_req_o   <= req_nxt;
         mem_we_o    <= we_nxt;
         mem_addr_o  <= addr_nxt;
         mem_wdata_o <= wdata_nxt;
         d_served    <= d_served_nxt;
         if_served   <= if_served_nxt;
         drop        <= drop_nxt;
         d_rdata_q   <= d_rdata_nxt;
         if_rdata_q  <= if_rdata_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed per-cycle vector bench for mem_port_arbiter
// Revision            : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        hold_i, flush_i, if_req_i, d_read_i, d_write_i, mem_ack_i;
   logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
   logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
   logic        if_done_o, d_done_o, stall_o, mem_req_o, mem_we_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hold_i     (hold_i),
      .flush_i    (flush_i),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_rdata_o (if_rdata_o),
      .if_done_o  (if_done_o),
      .d_read_i   (d_read_i),
      .d_write_i  (d_write_i),
      .d_addr_i   (d_addr_i),
      .d_wdata_i  (d_wdata_i),
      .d_rdata_o  (d_rdata_o),
      .d_done_o   (d_done_o),
      .stall_o    (stall_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_ack_i  (mem_ack_i),
      .mem_rdata_i(mem_rdata_i)
   );

   typedef struct {
      logic        hold, flush, if_req;
      logic [31:0] if_addr;
      logic        d_rd, d_wr;
      logic [31:0] d_addr, d_wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        e_stall, e_ifd, e_dd, e_req, e_we;
      logic [31:0] e_addr, e_wdata, e_ifr, e_dr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic hold, flush, if_req, input logic [31:0] if_addr,
                      input logic d_rd, d_wr, input logic [31:0] d_addr, d_wdata,
                      input logic ack, input logic [31:0] rdata,
                      input logic e_stall, e_ifd, e_dd, e_req, e_we,
                      input logic [31:0] e_addr, e_wdata, e_ifr, e_dr);
      vec_t v;
      v.hold = hold; v.flush = flush; v.if_req = if_req; v.if_addr = if_addr;
      v.d_rd = d_rd; v.d_wr = d_wr; v.d_addr = d_addr; v.d_wdata = d_wdata;
      v.ack = ack; v.rdata = rdata;
      v.e_stall = e_stall; v.e_ifd = e_ifd; v.e_dd = e_dd; v.e_req = e_req; v.e_we = e_we;
      v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_ifr = e_ifr; v.e_dr = e_dr;
      vecs.push_back(v);
   endtask

   task automatic clear_inputs();
      hold_i = 0; flush_i = 0; if_req_i = 0; if_addr_i = 0;
      d_read_i = 0; d_write_i = 0; d_addr_i = 0; d_wdata_i = 0;
      mem_ack_i = 0; mem_rdata_i = 0;
   endtask

   initial begin
      // hold flush ifreq ifaddr | rd wr daddr dwdata | ack rdata || stall ifd dd req we addr wdata if_rdata d_rdata
      // fetch 0x10, ack two cycles after the request
      add(0,0,1,32'h10, 0,0,0,0, 0,0,                  1,0,0,0,0, 32'h10-32'h10, 0, 0, 0);
      add(0,0,1,32'h10, 0,0,0,0, 0,0,                  1,0,0,1,0, 32'h10, 0, 0, 0);
      add(0,0,1,32'h10, 0,0,0,0, 0,0,                  1,0,0,1,0, 32'h10, 0, 0, 0);
      add(0,0,1,32'h10, 0,0,0,0, 1,32'h00500093,       0,1,0,1,0, 32'h10, 0, 32'h00500093, 0);
      add(0,0,0,0,      0,0,0,0, 0,0,                  0,0,0,0,0, 32'h10, 0, 32'h00500093, 0);
      // lw 0x40 and fetch 0x14 together, 1-cycle acks
      add(0,0,1,32'h14, 1,0,32'h40,0, 0,0,             1,0,0,0,0, 32'h10, 0, 32'h00500093, 0);
      add(0,0,1,32'h14, 1,0,32'h40,0, 1,32'h11112222,  1,0,1,1,0, 32'h40, 0, 32'h00500093, 32'h11112222);
      add(0,0,1,32'h14, 1,0,32'h40,0, 1,32'h33334444,  0,1,0,1,0, 32'h14, 0, 32'h33334444, 32'h11112222);
      add(0,0,0,0,      0,0,0,0, 0,0,                  0,0,0,0,0, 32'h14, 0, 32'h33334444, 32'h11112222);
      // sw 0x44 <- 0xDEADBEEF
      add(0,0,0,0, 0,1,32'h44,32'hDEADBEEF, 0,0,             1,0,0,0,0, 32'h14, 0, 32'h33334444, 32'h11112222);
      add(0,0,0,0, 0,1,32'h44,32'hDEADBEEF, 0,0,             1,0,0,1,1, 32'h44, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
      add(0,0,0,0, 0,1,32'h44,32'hDEADBEEF, 1,32'h55556666,  0,0,1,1,1, 32'h44, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
      add(0,0,0,0, 0,0,0,0, 0,0,                             0,0,0,0,0, 32'h44, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
      // load served while hold_i keeps the pipeline frozen
      add(1,0,0,0, 1,0,32'h48,0, 0,0,                  1,0,0,0,0, 32'h44, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
      add(1,0,0,0, 1,0,32'h48,0, 1,32'h77778888,       0,0,1,1,0, 32'h48, 0, 32'h33334444, 32'h77778888);
      add(1,0,0,0, 1,0,32'h48,0, 0,0,                  0,0,0,0,0, 32'h48, 0, 32'h33334444, 32'h77778888);
      add(1,0,0,0, 1,0,32'h48,0, 0,0,                  0,0,0,0,0, 32'h48, 0, 32'h33334444, 32'h77778888);
      add(0,0,0,0, 0,0,0,0, 0,0,                       0,0,0,0,0, 32'h48, 0, 32'h33334444, 32'h77778888);
      // flush during INST_WAIT of 0x20, then fetch 0x30
      add(0,0,1,32'h20, 0,0,0,0, 0,0,                  1,0,0,0,0, 32'h48, 0, 32'h33334444, 32'h77778888);
      add(0,1,1,32'h20, 0,0,0,0, 0,0,                  0,0,0,1,0, 32'h20, 0, 32'h33334444, 32'h77778888);
      add(0,0,1,32'h30, 0,0,0,0, 1,32'hBAD0BAD0,       1,0,0,1,0, 32'h20, 0, 32'h33334444, 32'h77778888);
      add(0,0,1,32'h30, 0,0,0,0, 0,0,                  1,0,0,0,0, 32'h20, 0, 32'h33334444, 32'h77778888);
      add(0,0,1,32'h30, 0,0,0,0, 1,32'h00A00113,       0,1,0,1,0, 32'h30, 0, 32'h00A00113, 32'h77778888);
      // stray ack in IDLE is ignored
      add(0,0,0,0,      0,0,0,0, 1,32'hFFFFFFFF,       0,0,0,0,0, 32'h30, 0, 32'h00A00113, 32'h77778888);
      // flush in the ack cycle suppresses the fetch completion
      add(0,0,1,32'h60, 0,0,0,0, 0,0,                  1,0,0,0,0, 32'h30, 0, 32'h00A00113, 32'h77778888);
      add(0,1,1,32'h60, 0,0,0,0, 1,32'h12345678,       0,0,0,1,0, 32'h60, 0, 32'h00A00113, 32'h77778888);
      add(0,0,0,0,      0,0,0,0, 0,0,                  0,0,0,0,0, 32'h60, 0, 32'h00A00113, 32'h77778888);

      clear_inputs();
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #2;
      chk("reset.mem_req",  {31'd0, mem_req_o}, 32'd0);
      chk("reset.mem_we",   {31'd0, mem_we_o},  32'd0);
      chk("reset.mem_addr", mem_addr_o,  32'd0);
      chk("reset.mem_wdata",mem_wdata_o, 32'd0);
      chk("reset.if_rdata", if_rdata_o,  32'd0);
      chk("reset.d_rdata",  d_rdata_o,   32'd0);
      chk("reset.stall",    {31'd0, stall_o},   32'd0);
      chk("reset.if_done",  {31'd0, if_done_o}, 32'd0);
      chk("reset.d_done",   {31'd0, d_done_o},  32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         hold_i = vecs[i].hold; flush_i = vecs[i].flush;
         if_req_i = vecs[i].if_req; if_addr_i = vecs[i].if_addr;
         d_read_i = vecs[i].d_rd; d_write_i = vecs[i].d_wr;
         d_addr_i = vecs[i].d_addr; d_wdata_i = vecs[i].d_wdata;
         mem_ack_i = vecs[i].ack; mem_rdata_i = vecs[i].rdata;
         #2;
         chk($sformatf("v%0d.stall", i),    {31'd0, stall_o},   {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d.if_done", i),  {31'd0, if_done_o}, {31'd0, vecs[i].e_ifd});
         chk($sformatf("v%0d.d_done", i),   {31'd0, d_done_o},  {31'd0, vecs[i].e_dd});
         chk($sformatf("v%0d.mem_req", i),  {31'd0, mem_req_o}, {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d.mem_we", i),   {31'd0, mem_we_o},  {31'd0, vecs[i].e_we});
         chk($sformatf("v%0d.mem_addr", i), mem_addr_o,  vecs[i].e_addr);
         chk($sformatf("v%0d.mem_wdata", i),mem_wdata_o, vecs[i].e_wdata);
         chk($sformatf("v%0d.if_rdata", i), if_rdata_o,  vecs[i].e_ifr);
         chk($sformatf("v%0d.d_rdata", i),  d_rdata_o,   vecs[i].e_dr);
      end

      // reset asserted mid-transaction in DATA_WAIT
      @(negedge clk_i);
      clear_inputs();
      d_read_i = 1; d_addr_i = 32'h50;
      #2;
      chk("rst.pre_stall", {31'd0, stall_o},   32'd1);
      chk("rst.pre_req",   {31'd0, mem_req_o}, 32'd0);
      @(negedge clk_i);
      #2;
      chk("rst.wait_req",  {31'd0, mem_req_o}, 32'd1);
      chk("rst.wait_addr", mem_addr_o, 32'h50);
      rst_i = 1'b0;
      #1;
      chk("rst.async_req",  {31'd0, mem_req_o}, 32'd0);
      chk("rst.async_addr", mem_addr_o, 32'd0);
      chk("rst.async_drd",  d_rdata_o,  32'd0);
      chk("rst.async_ifrd", if_rdata_o, 32'd0);
      chk("rst.async_stall",{31'd0, stall_o}, 32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      #2;
      chk("rst.rel_req",   {31'd0, mem_req_o}, 32'd0);
      chk("rst.rel_stall", {31'd0, stall_o},   32'd1);
      @(negedge clk_i);
      #2;
      chk("rst.reissue_req",  {31'd0, mem_req_o}, 32'd1);
      chk("rst.reissue_addr", mem_addr_o, 32'h50);
      chk("rst.reissue_done", {31'd0, d_done_o}, 32'd0);
      mem_ack_i = 1; mem_rdata_i = 32'h0BADF00D;
      #1;
      chk("rst.ack_done",  {31'd0, d_done_o}, 32'd1);
      chk("rst.ack_rdata", d_rdata_o, 32'h0BADF00D);
      chk("rst.ack_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk_i);
      clear_inputs();
      #2;
      chk("rst.end_req",   {31'd0, mem_req_o}, 32'd0);
      chk("rst.end_rdata", d_rdata_o, 32'h0BADF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
